// File: rtl/aes_pkg.sv
// Shared definitions for the sequential SubBytes engine: FSM encoding,
// state/word widths and GF(2^8) helpers used to build the S-boxes.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } sb_state_t;

  // Left-rotate a byte by n bits.
  function automatic logic [7:0] rotl8(logic [7:0] x, int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(logic [7:0] a);
    logic [7:0] b;
    b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    return gf_inv(b);
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Word-wide S-box: four byte lanes, forward always present; inverse lanes and
// the per-byte mode mux exist only when AES_SUBBYTES_SEQ_INV_EN is defined.

// Single forward S-box byte lane.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox_fwd(a);
endmodule

`ifdef AES_SUBBYTES_SEQ_INV_EN
// Single inverse S-box byte lane.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox_inv(a);
endmodule
`endif

module aes_sbox_word
  import aes_pkg::*;
#(
  parameter int NBYTES = AES_WORD_W / 8
) (
  input  logic [AES_WORD_W-1:0] word_in,
  input  logic                  mode,
  output logic [AES_WORD_W-1:0] word_out
);

  logic [NBYTES-1:0][7:0] b_in;
  logic [NBYTES-1:0][7:0] b_fwd;
  logic [NBYTES-1:0][7:0] b_out;

  assign b_in     = word_in;
  assign word_out = b_out;

  for (genvar g = 0; g < NBYTES; g++) begin : g_lane
    aes_sbox u_fwd (.a(b_in[g]), .y(b_fwd[g]));
`ifdef AES_SUBBYTES_SEQ_INV_EN
    logic [7:0] b_inv;
    aes_inv_sbox u_inv (.a(b_in[g]), .y(b_inv));
    assign b_out[g] = mode ? b_fwd[g] : b_inv;
`else
    assign b_out[g] = b_fwd[g];
`endif
  end

`ifndef AES_SUBBYTES_SEQ_INV_EN
  // Forward-only build: mode has no effect.
  logic unused_mode;
  assign unused_mode = mode;
`endif

endmodule

// File: rtl/aes_subbytes_seq_128.sv
// Sequential 128-bit SubBytes engine: one column per cycle through a shared
// word S-box. Optional macro AES_SUBBYTES_SEQ_INV_EN adds InvSubBytes,
// selected by enc_dec on accept; otherwise every request is forward.
module aes_subbytes_seq_128
  import aes_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   enc_dec,
  input  logic [AES_STATE_W-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] data_out,
  output logic                   busy
);

  sb_state_t state, state_nxt;
  logic [1:0] cnt;
  logic [1:0] slot;
  logic [NWORDS-1:0][AES_WORD_W-1:0] work;
  logic [AES_WORD_W-1:0] sbox_out;
  logic mode;

  // cnt 0 addresses the most significant word, i.e. packed index NWORDS-1.
  assign slot     = 2'(NWORDS - 1) - cnt;
  assign data_out = work;

  aes_sbox_word u_sbox (
    .word_in (work[slot]),
    .mode    (mode),
    .word_out(sbox_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt == 2'd3) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Work register and column counter: load on accept, substitute in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      work <= '0;
    end else if (state == S_IDLE && in_valid) begin
      cnt  <= 2'd0;
      work <= data_in;
    end else if (state == S_RUN) begin
      cnt        <= cnt + 2'd1;
      work[slot] <= sbox_out;
    end
  end

`ifdef AES_SUBBYTES_SEQ_INV_EN
  // Mode flop captured with the request so later enc_dec changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n)                         mode <= 1'b1;
    else if (state == S_IDLE && in_valid) mode <= enc_dec;
  end
`else
  assign mode = 1'b1;
  logic unused_enc_dec;
  assign unused_enc_dec = enc_dec;
`endif

endmodule

// File: tb/tb_aes_subbytes_seq_128.sv
// Self-checking bench for aes_subbytes_seq_128: table-driven S-box model,
// per-cycle protocol/data compare, directed vectors plus randomized requests.
module tb_aes_subbytes_seq_128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         enc_dec = 1'b1;
  logic [127:0] data_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] data_out;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  aes_subbytes_seq_128 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .enc_dec  (enc_dec),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .busy     (busy)
  );

  // ---------------- reference tables ----------------
  bit [7:0] tbl [256];
  bit [7:0] itbl[256];

  function automatic bit [7:0] rl(bit [7:0] q, int n);
    return (q << n) | (q >> (8 - n));
  endfunction

  // Walk generator 3 and its inverse together to fill the S-box table.
  task automatic build_tables();
    bit [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    tbl[0] = 8'h63;
    for (int i = 0; i < 256; i++) itbl[tbl[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model_sb(logic [127:0] d, bit fwd);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[i*8 +: 8] = fwd ? tbl[d[i*8 +: 8]] : itbl[d[i*8 +: 8]];
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Busy with a countdown to result; result held until consumed.
  bit           m_busy = 1'b0;
  int           m_wait = 0;
  logic [127:0] m_exp  = '0;
  logic [127:0] m_out  = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_wait = 0;
      m_out  = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_wait = 4;
`ifdef AES_SUBBYTES_SEQ_INV_EN
        m_exp  = model_sb(data_in, enc_dec);
`else
        m_exp  = model_sb(data_in, 1'b1);
`endif
      end
    end else if (m_wait > 0) begin
      m_wait = m_wait - 1;
    end else if (out_ready) begin
      m_busy = 1'b0;
      m_out  = m_exp;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", {127'd0, in_ready}, {127'd0, !m_busy});
      chk("busy", {127'd0, busy}, {127'd0, m_busy});
      chk("out_valid", {127'd0, out_valid}, {127'd0, m_busy && m_wait == 0});
      if (m_busy && m_wait == 0) chk("data_out", data_out, m_exp);
      else if (!m_busy)          chk("data_out_idle", data_out, m_out);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(logic [127:0] d, bit m, bit mutate);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    data_in  = d;
    enc_dec  = m;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = 1'b1;
      end
    end
    chk("accept_seen", {127'd0, acc}, 128'd1);
    in_valid = 1'b0;
    if (mutate) begin
      data_in = {$urandom, $urandom, $urandom, $urandom};
      enc_dec = ~m;
    end
  endtask

  // Called right after the accept edge; lat counts the accept edge as 1.
  task automatic wait_valid(output int lat);
    bit found;
    found = 1'b0;
    lat = 1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    chk("valid_seen", {127'd0, found}, 128'd1);
  endtask

  task automatic run_one(logic [127:0] d, bit m, bit mutate, string nm,
                         bit use_lit, logic [127:0] lit);
    int lat;
    out_ready = 1'b1;
    send(d, m, mutate);
    wait_valid(lat);
    chk({nm, "_lat"}, 128'(lat), 128'd5);
    if (use_lit) chk({nm, "_lit"}, data_out, lit);
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  initial begin
    logic [127:0] d, bp_a, bp_b;
    int lat, stall;
    bit m;

    build_tables();
    // Pin the model itself against known values.
    chk("tbl_00", 128'(tbl[8'h00]), 128'h63);
    chk("tbl_ff", 128'(tbl[8'hff]), 128'h16);
    chk("tbl_53", 128'(tbl[8'h53]), 128'hed);
    chk("itbl_63", 128'(itbl[8'h63]), 128'h00);
    chk("model_fips", model_sb(FIPS_IN, 1'b1), FIPS_OUT);
    chk("model_fips_inv", model_sb(FIPS_OUT, 1'b0), FIPS_IN);

    // Reset state.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors.
    run_one(FIPS_IN, 1'b1, 1'b0, "fips", 1'b1, FIPS_OUT);
`ifdef AES_SUBBYTES_SEQ_INV_EN
    run_one(FIPS_OUT, 1'b0, 1'b0, "fips_inv", 1'b1, FIPS_IN);
`else
    run_one(FIPS_OUT, 1'b0, 1'b0, "dec_ignored", 1'b0, '0);
`endif
    run_one('0, 1'b1, 1'b0, "zeros", 1'b1, {16{8'h63}});
    run_one({16{8'hff}}, 1'b1, 1'b0, "ones", 1'b1, {16{8'h16}});
    run_one({16{8'h53}}, 1'b1, 1'b0, "x53", 1'b1, {16{8'hed}});

    // Input mutation right after accept.
    run_one(FIPS_IN, 1'b1, 1'b1, "mutate", 1'b1, FIPS_OUT);

    // Backpressure with a competing request.
    bp_a = {$urandom, $urandom, $urandom, $urandom};
    bp_b = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    send(bp_a, 1'b1, 1'b0);
    wait_valid(lat);
    chk("bp_lat", 128'(lat), 128'd5);
    in_valid = 1'b1;
    data_in  = bp_b;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("bp_hold", data_out, model_sb(bp_a, 1'b1));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_busy", {127'd0, busy}, 128'd1);
    wait_valid(lat);
    chk("bp_new_lat", 128'(lat), 128'd5);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN.
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_dout", data_out, 128'd0);
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    run_one(FIPS_IN, 1'b1, 1'b0, "post_rst", 1'b1, FIPS_OUT);

    // Randomized requests with random consumer stalls.
    for (int it = 0; it < 40; it++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      send(d, m, 1'($urandom_range(0, 1)));
      wait_valid(lat);
      chk("rand_lat", 128'(lat), 128'd5);
      repeat (stall) begin
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_subbytes_seq_128.md
Name: aes_subbytes_seq_128

Overview:
- Sequential 128-bit SubBytes/InvSubBytes engine: accepts a full AES state and drives it one 32-bit column per cycle through a shared 4-S-box word datapath.
- Collects the four substituted words and returns the 128-bit result over a valid/ready handshake.
- Sits between the round controller and the shared word S-box; it initiates every S-box word transaction.
- Trades 4x fewer S-boxes for a multi-cycle latency.

Parameters:
- NWORDS, 4, columns per state; fixed for AES-128 state width, not to be overridden.

Ports:
- clk        in   1    rising-edge clock
- rst_n      in   1    synchronous active-low reset
- in_valid   in   1    request valid
- in_ready   out  1    engine can accept a request
- enc_dec    in   1    1 = forward S-box (encrypt), 0 = inverse (decrypt); sampled on accept
- data_in    in   128  input state; byte 0 = bits [127:120], column-major
- out_valid  out  1    result valid
- out_ready  in   1    consumer accepts result
- data_out   out  128  substituted state
- busy       out  1    high in RUN or DONE

Behaviour:
- Reset (rst_n low at a clk edge): state = IDLE, word counter = 0, in_ready = 1, out_valid = 0, busy = 0, data_out = 0. Reset mid-operation abandons the request; no partial result is ever presented.
- FSM IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch data_in into a 128-bit work register, latch enc_dec into a mode flop, clear cnt, go to RUN.
- FSM RUN:
  - in_ready = 0.
  - Each cycle, word cnt of the work register (cnt 0 = bits [127:96], cnt 3 = bits [31:0]) is presented to the word S-box.
  - The combinational result is written back into the same word slot; cnt increments.
  - When cnt == 3, write word 3 and go to DONE.
- FSM DONE:
  - out_valid = 1; data_out = work register, held stable until the handshake completes.
  - On out_ready: out_valid drops next cycle and the FSM returns to IDLE.
  - in_ready stays 0 in DONE; there is no overlap of requests.
- Latency:
  - Accept edge at cycle 0; words substituted at the edges ending cycles 1..4.
  - out_valid is high from cycle 5.
  - Minimum back-to-back throughput is one state per 6 cycles.
- Changes to data_in or enc_dec after the accept edge have no effect.
- out_ready while out_valid = 0 is ignored.
- cnt is 2 bits; no wrap beyond 3 occurs because RUN exits at 3.
- data_out retains the last result in IDLE (not cleared), except after reset.

Optional Feature:
- Macro: AES_SUBBYTES_SEQ_INV_EN.
- Defined:
  - Inverse S-boxes are instantiated; enc_dec selects forward or inverse as described above.
- Undefined:
  - Only forward S-boxes are instantiated.
  - The mode flop is removed and enc_dec is ignored; every request is forward SubBytes.
  - Latency and the handshake are unchanged.

Decomposition:
- Shared package aes_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - AES_STATE_W=128, AES_WORD_W=32.
- One sub-module, aes_sbox_word:
  - Combinational: 32-bit word plus mode in, 32-bit word out.
  - Instantiates four aes_sbox, plus four aes_inv_sbox under the macro, with a bytewise mux.
- The top module holds the FSM, counter, work register and handshake.

Test Plan:
- Forward FIPS-197 App. B round-1 vector:
  - Stimulus: data_in = 193de3bea0f4e22b9ac68d2ae9f84808, enc_dec = 1, out_ready = 1.
  - Response: data_out = d42711aee0bf98f1b8b45de51e415230; out_valid exactly 5 cycles after accept.
- Inverse (macro defined):
  - Stimulus: data_in = d42711aee0bf98f1b8b45de51e415230, enc_dec = 0.
  - Response: data_out = 193de3bea0f4e22b9ac68d2ae9f84808.
- Corner bytes:
  - All-zero input with enc_dec = 1 -> 63636363...63.
  - All-FF input -> 1616...16.
  - Input 0x53 repeated -> ED repeated.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles after out_valid; in_valid pulsed with a new state during that time.
  - Response: data_out stable, in_ready = 0, new request not accepted.
  - After out_ready = 1: IDLE next cycle, and the next request is accepted.
- Reset mid-RUN:
  - Stimulus: rst_n low at cycle 2 of RUN.
  - Response: next edge gives out_valid = 0, in_ready = 1, busy = 0, data_out = 0; a fresh request afterwards produces the correct result.
- Input mutation:
  - Stimulus: change data_in and enc_dec the cycle after accept.
  - Response: result matches the originally latched values.
